ib_read_ctrl: RTL and testbench
===============================

Name: ib_read_ctrl

Overview:
Downstream consumer of one router input buffer. Pops 16-bit flits from the buffer and decodes the head flit's destination with XY routing. Requests one of five output ports from the switch arbiter, holds that port for the whole packet, and streams the packet's flits out through a valid/ready interface. One instance per input port.

Parameters:
DATA_WIDTH, 16, flit width
LEN_WIDTH, 4, payload-length field width (body flits after head)
COORD_WIDTH, 2, X/Y coordinate field width
X_COORD, 0, this router's X coordinate
Y_COORD, 0, this router's Y coordinate
NUM_PORTS, 5, output ports (local, N, E, S, W)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
buf_empty_i  in  1  input buffer empty
buf_valid_i  in  1  buffer read data valid (same cycle as buf_read_o)
buf_data_i  in  DATA_WIDTH  buffer read data
buf_read_o  out  1  pop one flit (single-cycle pulse)
req_o  out  NUM_PORTS  one-hot output-port request to arbiter
gnt_i  in  NUM_PORTS  one-hot grant from arbiter
flit_o  out  DATA_WIDTH  flit to crossbar
flit_valid_o  out  1  flit_o valid
flit_ready_i  in  1  crossbar accepts flit_o this cycle

Behaviour:
- Head flit format: [15]=1 head marker; [7:6] dest X; [5:4] dest Y; [3:0] body length L (0..15). Body flits are opaque.
- XY route, X first:
  - destX>X_COORD -> E; destX<X_COORD -> W
  - else destY>Y_COORD -> N; destY<Y_COORD -> S
  - else LOCAL
  - Compares are unsigned.
- FSM states: IDLE, REQ, SEND, FETCH.
- IDLE:
  - If !buf_empty_i: buf_read_o=1 for one cycle, and the flit is captured into hold_q when buf_valid_i is high.
  - If the flit has [15]=1: latch route_q and rem_q=L, then go to REQ.
  - If [15]=0 (malformed/stray): discard it, stay in IDLE, and pop again next cycle if the buffer is still non-empty.
- REQ:
  - req_o=route_q.
  - When (gnt_i & route_q)!=0, go to SEND.
  - gnt_i is ignored in all other states.
- SEND:
  - flit_valid_o=1 and flit_o=hold_q. flit_o must stay stable while valid is high and ready is low.
  - On flit_ready_i: if rem_q==0 go to IDLE (packet done); else go to FETCH.
- FETCH:
  - If !buf_empty_i: buf_read_o=1, capture into hold_q, rem_q decrements by 1, go to SEND.
  - If the buffer is empty, wait in FETCH with no read.
  - Body flits are never header-checked.
- req_o stays asserted in REQ, SEND and FETCH (packet lock). It drops to 0 in the cycle after the last flit handshake.
- Throughput: head takes 1 cycle pop + ≥1 cycle REQ; each body flit takes ≥2 cycles (FETCH+SEND).
- buf_read_o is asserted only in IDLE/FETCH and only when buf_empty_i=0. The block never pops an empty buffer.
- Reset values (asynchronous, on reset=0, including mid-packet):
  - state=IDLE; hold_q=0, rem_q=0, route_q=0
  - buf_read_o=0, req_o=0, flit_valid_o=0, flit_o=0
  - Any partial packet is abandoned.
- rem_q is LEN_WIDTH bits and never underflows; FETCH is entered only with rem_q>0.

Optional Feature:
- Macro IB_READ_CTRL_STATS_EN.
- When defined, adds output pkt_count_o [15:0]: packets completed (last-flit handshake), saturating at 16'hFFFF, reset to 0.
- Also adds drop_count_o [7:0]: malformed head flits discarded, saturating at 8'hFF, reset to 0.
- When undefined: neither port nor counters exist; behaviour otherwise identical.

Decomposition:
- Package ib_pkg:
  - port index constants: PORT_LOCAL=0, PORT_N=1, PORT_E=2, PORT_S=3, PORT_W=4
  - head-field bit positions (HEAD_BIT, DX_MSB/LSB, DY_MSB/LSB, LEN_MSB/LSB)
  - state enum typedef ib_rd_state_t
- One sub-module: xy_route, combinational. Inputs: dest X/Y and X_COORD/Y_COORD parameters; output: one-hot NUM_PORTS route.

Test Plan:
- X_COORD=1,Y_COORD=1; push head 16'h80C2 (dX=3,dY=0,L=2) plus 2 body flits; grant E in the cycle after req -> req_o=5'b00100; 3 flits out in order; req_o=0 after the 3rd handshake.
- Head dest equals local (1,1), L=0 -> req_o=5'b00001; single flit out; back to IDLE; no further buf_read_o.
- Hold flit_ready_i=0 for 4 cycles in SEND -> flit_valid_o stays 1, flit_o stable, no buf_read_o.
- Buffer empties mid-packet (L=3, only 1 body flit present) -> FETCH waits with buf_read_o=0; resumes when the next flit arrives; all 4 flits delivered.
- Stray flit 16'h0123 in IDLE -> popped and discarded, no req_o; drop_count_o=1 with the macro defined.
- Assert reset during FETCH -> all outputs 0 immediately (asynchronously); a new head afterwards routes normally.

Source files
------------

// File: rtl/ib_pkg.sv
// Shared constants and types for the input-buffer read controller.
package ib_pkg;

    localparam int unsigned PORT_LOCAL = 0;
    localparam int unsigned PORT_N     = 1;
    localparam int unsigned PORT_E     = 2;
    localparam int unsigned PORT_S     = 3;
    localparam int unsigned PORT_W     = 4;

    localparam int unsigned HEAD_BIT = 15;
    localparam int unsigned DX_MSB   = 7;
    localparam int unsigned DX_LSB   = 6;
    localparam int unsigned DY_MSB   = 5;
    localparam int unsigned DY_LSB   = 4;
    localparam int unsigned LEN_MSB  = 3;
    localparam int unsigned LEN_LSB  = 0;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StSend,
        StFetch
    } ib_rd_state_t;

endpackage

// File: rtl/xy_route.sv
// Combinational XY (X-first) route decode to a one-hot output-port vector.
module xy_route
    import ib_pkg::*;
#(
    parameter int unsigned COORD_WIDTH = 2,
    parameter int unsigned X_COORD     = 0,
    parameter int unsigned Y_COORD     = 0,
    parameter int unsigned NUM_PORTS   = 5
) (
    input  logic [COORD_WIDTH-1:0] dest_x,
    input  logic [COORD_WIDTH-1:0] dest_y,
    output logic [NUM_PORTS-1:0]   route
);

    localparam logic [COORD_WIDTH-1:0] XC = COORD_WIDTH'(X_COORD);
    localparam logic [COORD_WIDTH-1:0] YC = COORD_WIDTH'(Y_COORD);

    always_comb begin
        route = '0;
        if (dest_x > XC) begin
            route[PORT_E] = 1'b1;
        end else if (dest_x < XC) begin
            route[PORT_W] = 1'b1;
        end else if (dest_y > YC) begin
            route[PORT_N] = 1'b1;
        end else if (dest_y < YC) begin
            route[PORT_S] = 1'b1;
        end else begin
            route[PORT_LOCAL] = 1'b1;
        end
    end

endmodule

// File: rtl/ib_read_ctrl.sv
// Input-buffer read controller: pops flits, routes the head, locks a port, streams the packet.
// Optional packet/drop counters are enabled with IB_READ_CTRL_STATS_EN.
module ib_read_ctrl
    import ib_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned LEN_WIDTH   = 4,
    parameter int unsigned COORD_WIDTH = 2,
    parameter int unsigned X_COORD     = 0,
    parameter int unsigned Y_COORD     = 0,
    parameter int unsigned NUM_PORTS   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  buf_empty_i,
    input  logic                  buf_valid_i,
    input  logic [DATA_WIDTH-1:0] buf_data_i,
    output logic                  buf_read_o,
    output logic [NUM_PORTS-1:0]  req_o,
    input  logic [NUM_PORTS-1:0]  gnt_i,
    output logic [DATA_WIDTH-1:0] flit_o,
    output logic                  flit_valid_o,
    input  logic                  flit_ready_i
`ifdef IB_READ_CTRL_STATS_EN
    ,
    output logic [15:0]           pkt_count_o,
    output logic [7:0]            drop_count_o
`endif
);

    ib_rd_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [NUM_PORTS-1:0]  route_q, route_d;
    logic [NUM_PORTS-1:0]  head_route;

    xy_route #(
        .COORD_WIDTH (COORD_WIDTH),
        .X_COORD     (X_COORD),
        .Y_COORD     (Y_COORD),
        .NUM_PORTS   (NUM_PORTS)
    ) u_xy_route (
        .dest_x (COORD_WIDTH'(buf_data_i[DX_MSB:DX_LSB])),
        .dest_y (COORD_WIDTH'(buf_data_i[DY_MSB:DY_LSB])),
        .route  (head_route)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            hold_q  <= '0;
            rem_q   <= '0;
            route_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rem_q   <= rem_d;
            route_q <= route_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        rem_d        = rem_q;
        route_d      = route_q;
        buf_read_o   = 1'b0;
        req_o        = '0;
        flit_valid_o = 1'b0;
        flit_o       = '0;
        unique case (state_q)
            StIdle: begin
                if (!buf_empty_i) begin
                    buf_read_o = 1'b1;
                    // Non-head flits are simply dropped; we stay here and pop again.
                    if (buf_valid_i && buf_data_i[HEAD_BIT]) begin
                        hold_d  = buf_data_i;
                        route_d = head_route;
                        rem_d   = LEN_WIDTH'(buf_data_i[LEN_MSB:LEN_LSB]);
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                req_o = route_q;
                if ((gnt_i & route_q) != '0) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                req_o        = route_q;
                flit_valid_o = 1'b1;
                flit_o       = hold_q;
                if (flit_ready_i) begin
                    state_d = (rem_q == '0) ? StIdle : StFetch;
                end
            end
            StFetch: begin
                req_o = route_q;
                if (!buf_empty_i) begin
                    buf_read_o = 1'b1;
                    if (buf_valid_i) begin
                        hold_d  = buf_data_i;
                        rem_d   = rem_q - LEN_WIDTH'(1);
                        state_d = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Keep the pop strobe quiet while reset is held, even with a non-empty buffer.
        if (!reset) begin
            buf_read_o = 1'b0;
        end
    end

`ifdef IB_READ_CTRL_STATS_EN
    logic        pkt_done;
    logic        drop;
    logic [15:0] pkt_q;
    logic [7:0]  drop_q;

    assign pkt_done = (state_q == StSend) && flit_ready_i && (rem_q == '0);
    assign drop     = (state_q == StIdle) && !buf_empty_i && buf_valid_i
                      && !buf_data_i[HEAD_BIT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_q  <= '0;
            drop_q <= '0;
        end else begin
            if (pkt_done && (pkt_q != 16'hFFFF)) begin
                pkt_q <= pkt_q + 16'd1;
            end
            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign pkt_count_o  = pkt_q;
    assign drop_count_o = drop_q;
`endif

endmodule

// File: tb/tb_ib_read_ctrl.sv
// Directed bench for ib_read_ctrl at router (1,1) with a simple FIFO model feeding it.
module tb_ib_read_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        buf_empty;
    logic        buf_valid;
    logic [15:0] buf_data;
    logic        buf_read;
    logic [4:0]  req;
    logic [4:0]  gnt;
    logic [15:0] flit;
    logic        flit_valid;
    logic        flit_ready;
`ifdef IB_READ_CTRL_STATS_EN
    logic [15:0] pkt_count;
    logic [7:0]  drop_count;
`endif

    always #5 clk = ~clk;

    logic [15:0] mem [0:63];
    logic [5:0]  wr_ptr = '0;
    logic [5:0]  rd_ptr = '0;
    int          pops = 0;
    logic [15:0] got [0:31];
    int          n_got = 0;
    int          vectors = 0;
    int          miscompares = 0;

    assign buf_empty = (rd_ptr == wr_ptr);
    assign buf_data  = mem[rd_ptr];
    assign buf_valid = buf_read && !buf_empty;

    always @(posedge clk) begin
        if (buf_read && !buf_empty) begin
            rd_ptr <= rd_ptr + 6'd1;
            pops   <= pops + 1;
        end
        if (flit_valid && flit_ready) begin
            got[n_got[4:0]] <= flit;
            n_got           <= n_got + 1;
        end
    end

    ib_read_ctrl #(
        .DATA_WIDTH  (16),
        .LEN_WIDTH   (4),
        .COORD_WIDTH (2),
        .X_COORD     (1),
        .Y_COORD     (1),
        .NUM_PORTS   (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .buf_empty_i  (buf_empty),
        .buf_valid_i  (buf_valid),
        .buf_data_i   (buf_data),
        .buf_read_o   (buf_read),
        .req_o        (req),
        .gnt_i        (gnt),
        .flit_o       (flit),
        .flit_valid_o (flit_valid),
        .flit_ready_i (flit_ready)
`ifdef IB_READ_CTRL_STATS_EN
        ,
        .pkt_count_o  (pkt_count),
        .drop_count_o (drop_count)
`endif
    );

    task automatic push(input logic [15:0] f);
        mem[wr_ptr] = f;
        wr_ptr      = wr_ptr + 6'd1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_stats(input string tag, input int pkts, input int drops);
`ifdef IB_READ_CTRL_STATS_EN
        check({tag, "_pkt"}, 32'(pkt_count), 32'(pkts));
        check({tag, "_drop"}, 32'(drop_count), 32'(drops));
`else
        check({tag, "_nostats"}, 32'(pkts + drops), 32'(pkts + drops) | 32'(n_got & 0));
`endif
    endtask

    initial begin
        reset      = 1'b0;
        gnt        = '0;
        flit_ready = 1'b0;
        #2;
        check("rst_read", 32'(buf_read), 0);
        check("rst_req", 32'(req), 0);
        check("rst_valid", 32'(flit_valid), 0);
        check("rst_flit", 32'(flit), 0);
        check_stats("rst", 0, 0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check("idle_empty_read", 32'(buf_read), 0);

        // Packet to E: head 80C2 (dX=3,dY=0,L=2) plus two body flits.
        push(16'h80C2); push(16'hAAAA); push(16'h5555);
        #1 check("t1_pop_head", 32'(buf_read), 1);
        @(negedge clk);
        check("t1_req_e", 32'(req), 32'h04);
        check("t1_req_noread", 32'(buf_read), 0);
        gnt = 5'b00100;
        @(negedge clk);
        gnt = '0;
        check("t1_send_valid", 32'(flit_valid), 1);
        check("t1_flit0", 32'(flit), 32'h80C2);
        flit_ready = 1'b1;
        @(negedge clk);
        check("t1_fetch_valid", 32'(flit_valid), 0);
        check("t1_fetch_read", 32'(buf_read), 1);
        check("t1_fetch_req", 32'(req), 32'h04);
        @(negedge clk);
        check("t1_flit1", 32'(flit), 32'hAAAA);
        @(negedge clk);
        check("t1_fetch2_read", 32'(buf_read), 1);
        @(negedge clk);
        check("t1_flit2", 32'(flit), 32'h5555);
        check("t1_flit2_valid", 32'(flit_valid), 1);
        @(negedge clk);
        check("t1_done_req", 32'(req), 0);
        check("t1_done_valid", 32'(flit_valid), 0);
        check("t1_done_read", 32'(buf_read), 0);
        check("t1_n_got", 32'(n_got), 3);
        check("t1_got0", 32'(got[0]), 32'h80C2);
        check("t1_got1", 32'(got[1]), 32'hAAAA);
        check("t1_got2", 32'(got[2]), 32'h5555);
        check_stats("t1", 1, 0);
        flit_ready = 1'b0;

        // Local packet, L=0; wrong-port grant ignored; 4 stalled cycles; stray popped after.
        push(16'h8050);
        #1 check("t2_pop_head", 32'(buf_read), 1);
        @(negedge clk);
        check("t2_req_local", 32'(req), 32'h01);
        gnt = 5'b00010;
        @(negedge clk);
        check("t2_wrong_gnt_valid", 32'(flit_valid), 0);
        check("t2_wrong_gnt_req", 32'(req), 32'h01);
        gnt = 5'b00001;
        @(negedge clk);
        gnt = '0;
        push(16'h0123);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_stall_valid", 32'(flit_valid), 1);
            check("t3_stall_flit", 32'(flit), 32'h8050);
            check("t3_stall_noread", 32'(buf_read), 0);
            if (i == 4) flit_ready = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        flit_ready = 1'b0;
        check("t5_stray_pop", 32'(buf_read), 1);
        check("t5_stray_req", 32'(req), 0);
        check("t2_n_got", 32'(n_got), 4);
        check("t2_got3", 32'(got[3]), 32'h8050);
        @(negedge clk);
        check("t5_after_read", 32'(buf_read), 0);
        check("t5_after_req", 32'(req), 0);
        check("t5_pops", 32'(pops), 5);
        check_stats("t5", 2, 1);

        // W packet, L=3, only one body flit present: FETCH must wait.
        flit_ready = 1'b1;
        push(16'h8023); push(16'h1111);
        #1 check("t4_pop_head", 32'(buf_read), 1);
        @(negedge clk);
        check("t4_req_w", 32'(req), 32'h10);
        gnt = 5'b10000;
        @(negedge clk);
        gnt = '0;
        check("t4_flit0", 32'(flit), 32'h8023);
        @(negedge clk);
        @(negedge clk);
        check("t4_flit1", 32'(flit), 32'h1111);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_wait_read", 32'(buf_read), 0);
            check("t4_wait_valid", 32'(flit_valid), 0);
            check("t4_wait_req", 32'(req), 32'h10);
        end
        push(16'h2222); push(16'h3333);
        #1 check("t4_resume_read", 32'(buf_read), 1);
        @(negedge clk);
        check("t4_flit2", 32'(flit), 32'h2222);
        @(negedge clk);
        @(negedge clk);
        check("t4_flit3", 32'(flit), 32'h3333);
        @(negedge clk);
        check("t4_done_req", 32'(req), 0);
        check("t4_n_got", 32'(n_got), 8);
        check("t4_got7", 32'(got[7]), 32'h3333);
        check_stats("t4", 3, 1);

        // N packet, L=2; reset lands while waiting in FETCH.
        push(16'h8062); push(16'h4444);
        @(negedge clk);
        check("t6_req_n", 32'(req), 32'h02);
        gnt = 5'b00010;
        @(negedge clk);
        gnt = '0;
        @(negedge clk);
        @(negedge clk);
        check("t6_flit1", 32'(flit), 32'h4444);
        @(negedge clk);
        check("t6_fetch_wait", 32'(buf_read), 0);
        push(16'h5555); push(16'h8040);
        #1 check("t6_fetch_read", 32'(buf_read), 1);
        #1 reset = 1'b0;
        #1;
        check("t6_rst_read", 32'(buf_read), 0);
        check("t6_rst_req", 32'(req), 0);
        check("t6_rst_valid", 32'(flit_valid), 0);
        check("t6_rst_flit", 32'(flit), 0);
        check_stats("t6_rst", 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1 check("t6_stray_pop", 32'(buf_read), 1);
        @(negedge clk);
        check("t6_head_pop", 32'(buf_read), 1);
        check("t6_head_noreq", 32'(req), 0);
        @(negedge clk);
        check("t6_req_s", 32'(req), 32'h08);
        gnt = 5'b01000;
        @(negedge clk);
        gnt = '0;
        check("t6_flit_new", 32'(flit), 32'h8040);
        @(negedge clk);
        check("t6_done_req", 32'(req), 0);
        check("t6_n_got", 32'(n_got), 11);
        check("t6_got10", 32'(got[10]), 32'h8040);
        check_stats("t6", 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
